// File: rtl/uart_clk_pkg.sv
// Shared types and defaults for the UART baud-clock scheduler.
// Imported by uart_clk_div and uart_clk_ctrl.
package uart_clk_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    RUN    = 2'd1,
    RELOAD = 2'd2
  } uart_clk_state_e;

  localparam int OSR_DEFAULT   = 16;
  localparam int DIV_W_DEFAULT = 16;

  // Width of a phase counter that wraps every osr oversample ticks.
  function automatic int PHASE_W(input int osr);
    return $clog2(osr);
  endfunction

endpackage

// File: rtl/uart_clk_div.sv
// Loadable down-counter producing the registered oversample strobe.
// Optional fractional dither when UART_CLK_CTRL_DITHER_EN is defined.
module uart_clk_div
  import uart_clk_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             suppress,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
`ifdef UART_CLK_CTRL_DITHER_EN
  input  logic [3:0]       frac,
`endif
  output logic             tick,
  output logic             tick_nxt
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] reload_val;

`ifdef UART_CLK_CTRL_DITHER_EN
  logic [3:0] acc;
  logic [3:0] acc_nxt;
  logic [4:0] acc_sum;

  // A carry out of the accumulator stretches the next period by one clock.
  always_comb begin
    acc_sum    = {1'b0, acc} + {1'b0, frac};
    reload_val = acc_sum[4] ? (div + DIV_ONE) : div;
  end
`else
  assign reload_val = div;
`endif

  // tick_nxt predicts the strobe so it can be registered alongside the count.
  always_comb begin
    cnt_nxt  = cnt;
    tick_nxt = 1'b0;
`ifdef UART_CLK_CTRL_DITHER_EN
    acc_nxt  = acc;
`endif
    if (clear) begin
      cnt_nxt = '0;
`ifdef UART_CLK_CTRL_DITHER_EN
      acc_nxt = '0;
`endif
    end else if (load) begin
      cnt_nxt  = div;
      tick_nxt = !suppress && (div == '0);
`ifdef UART_CLK_CTRL_DITHER_EN
      acc_nxt  = '0;
`endif
    end else if (run) begin
      if (cnt == '0) begin
        cnt_nxt = reload_val;
`ifdef UART_CLK_CTRL_DITHER_EN
        acc_nxt = acc_sum[3:0];
`endif
      end else begin
        cnt_nxt = cnt - DIV_ONE;
      end
      tick_nxt = (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
`ifdef UART_CLK_CTRL_DITHER_EN
      acc  <= '0;
`endif
    end else begin
      cnt  <= cnt_nxt;
      tick <= tick_nxt;
`ifdef UART_CLK_CTRL_DITHER_EN
      acc  <= acc_nxt;
`endif
    end
  end

endmodule

// File: rtl/uart_clk_ctrl.sv
// Baud-clock scheduler: oversample, TX bit and RX mid-bit strobes from one divider.
// Define UART_CLK_CTRL_DITHER_EN to enable fractional divisor dither via cfg_frac.
module uart_clk_ctrl
  import uart_clk_pkg::*;
#(
  parameter int          DIV_W       = DIV_W_DEFAULT,
  parameter int          OSR         = OSR_DEFAULT,
  parameter int unsigned DEFAULT_DIV = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [3:0]       cfg_frac,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             tx_busy,
  input  logic             rx_busy,
  input  logic             rx_start,
  output logic             os_tick,
  output logic             tx_tick,
  output logic             rx_sample
);

  localparam int               PW      = PHASE_W(OSR);
  localparam logic [PW-1:0]    PH_LAST = PW'(OSR - 1);
  localparam logic [PW-1:0]    PH_MID  = PW'(OSR / 2 - 1);
  localparam logic [PW-1:0]    PH_ONE  = PW'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  uart_clk_state_e state;
  uart_clk_state_e state_nxt;

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_src;
  logic [PW-1:0]    tx_phase;
  logic [PW-1:0]    tx_phase_nxt;
  logic [PW-1:0]    rx_phase;
  logic [PW-1:0]    rx_phase_nxt;
  logic             accept;
  logic             div_clear;
  logic             div_load;
  logic             div_suppress;
  logic             div_run;
  logic             tick_nxt;

`ifdef UART_CLK_CTRL_DITHER_EN
  logic [3:0] frac_q;
`else
  logic unused_frac;
  assign unused_frac = ^cfg_frac;
`endif

  // Divisor changes are only taken while both engines sit between frames.
  assign cfg_ready = !tx_busy && !rx_busy && (state != RELOAD);
  assign accept    = cfg_valid && cfg_ready;
  assign div_src   = accept ? cfg_div : div_q;

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = OFF;
    end else begin
      case (state)
        OFF:     state_nxt = RUN;
        RUN:     state_nxt = accept ? RELOAD : RUN;
        RELOAD:  state_nxt = RUN;
        default: state_nxt = OFF;
      endcase
    end
  end

  // rx_start re-anchors the divider to the start edge and swallows any tick due now.
  always_comb begin
    div_clear    = 1'b0;
    div_load     = 1'b0;
    div_suppress = 1'b0;
    div_run      = 1'b0;
    if (state_nxt != RUN) begin
      div_clear = 1'b1;
    end else if (state != RUN) begin
      div_load = 1'b1;
    end else if (rx_start) begin
      div_load     = 1'b1;
      div_suppress = 1'b1;
    end else begin
      div_run = 1'b1;
    end
  end

  always_comb begin
    tx_phase_nxt = '0;
    rx_phase_nxt = '0;
    if (state == RUN && state_nxt == RUN) begin
      tx_phase_nxt = os_tick ? (tx_phase + PH_ONE) : tx_phase;
      if (!rx_start) begin
        rx_phase_nxt = os_tick ? (rx_phase + PH_ONE) : rx_phase;
      end
    end
  end

  uart_clk_div #(
    .DIV_W(DIV_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (div_clear),
    .load     (div_load),
    .suppress (div_suppress),
    .run      (div_run),
    .div      (div_src),
`ifdef UART_CLK_CTRL_DITHER_EN
    .frac     (accept ? cfg_frac : frac_q),
`endif
    .tick     (os_tick),
    .tick_nxt (tick_nxt)
  );

  // Phase strobes are registered off the predicted tick so they align with os_tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= OFF;
      div_q     <= DIV_RST;
      tx_phase  <= '0;
      rx_phase  <= '0;
      tx_tick   <= 1'b0;
      rx_sample <= 1'b0;
`ifdef UART_CLK_CTRL_DITHER_EN
      frac_q    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      tx_phase  <= tx_phase_nxt;
      rx_phase  <= rx_phase_nxt;
      tx_tick   <= tick_nxt && (tx_phase_nxt == PH_LAST);
      rx_sample <= tick_nxt && (rx_phase_nxt == PH_MID) && rx_busy;
      if (accept) begin
        div_q <= cfg_div;
`ifdef UART_CLK_CTRL_DITHER_EN
        frac_q <= cfg_frac;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_clk_ctrl.sv
// Directed self-checking bench for uart_clk_ctrl (DIV_W=16, OSR=16, DEFAULT_DIV=26).
// Honours UART_CLK_CTRL_DITHER_EN when choosing the dithered-period expectation.
module tb_uart_clk_ctrl;

`ifdef UART_CLK_CTRL_DITHER_EN
  localparam int DITHER_SUM = 336;
`else
  localparam int DITHER_SUM = 320;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] cfg_div;
  logic [3:0]  cfg_frac;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        tx_busy;
  logic        rx_busy;
  logic        rx_start;
  logic        os_tick;
  logic        tx_tick;
  logic        rx_sample;

  int checks   = 0;
  int failures = 0;
  int gap;
  int total;
  int count;

  uart_clk_ctrl #(
    .DIV_W      (16),
    .OSR        (16),
    .DEFAULT_DIV(26)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_div   (cfg_div),
    .cfg_frac  (cfg_frac),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .tx_busy   (tx_busy),
    .rx_busy   (rx_busy),
    .rx_start  (rx_start),
    .os_tick   (os_tick),
    .tx_tick   (tx_tick),
    .rx_sample (rx_sample)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [15:0] d, input logic [3:0] f,
                               input logic v, input logic tb, input logic rb,
                               input logic rs);
    en        = e;
    cfg_div   = d;
    cfg_frac  = f;
    cfg_valid = v;
    tx_busy   = tb;
    rx_busy   = rb;
    rx_start  = rs;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic strobe(input int sel);
    case (sel)
      0:       return os_tick;
      1:       return tx_tick;
      default: return rx_sample;
    endcase
  endfunction

  // Cycles until the selected strobe is seen; -1 if the bound expires.
  task automatic waitStrobe(input int sel, input int limit, output int n);
    bit found;
    found = 1'b0;
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      if (!found) begin
        step(1);
        if (strobe(sel)) begin
          found = 1'b1;
          n = i;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    checkOutput("reset_os_tick", {31'd0, os_tick}, 32'd0);
    checkOutput("reset_tx_tick", {31'd0, tx_tick}, 32'd0);
    checkOutput("reset_rx_sample", {31'd0, rx_sample}, 32'd0);
    checkOutput("reset_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    tx_busy = 1'b1;
    #1;
    checkOutput("ready_tx_busy", {31'd0, cfg_ready}, 32'd0);
    tx_busy = 1'b0;

    // Default divisor 26: period 27, tx every 16 ticks.
    rst_n = 1'b1;
    en    = 1'b1;
    waitStrobe(0, 100, gap);
    checkOutput("first_os_gap", gap, 32'd27);
    step(1);
    checkOutput("os_one_cycle", {31'd0, os_tick}, 32'd0);
    waitStrobe(0, 100, gap);
    checkOutput("second_os_gap", gap, 32'd26);
    waitStrobe(1, 1000, gap);
    checkOutput("first_tx_gap", gap, 32'd378);
    checkOutput("tx_with_os", {31'd0, os_tick}, 32'd1);
    waitStrobe(1, 1000, gap);
    checkOutput("tx_period", gap, 32'd432);

    // Blocked config while TX busy, then accept.
    applyStimulus(1'b1, 16'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("ready_blocked", {31'd0, cfg_ready}, 32'd0);
    waitStrobe(0, 100, gap);
    checkOutput("old_period_kept", gap, 32'd27);
    tx_busy = 1'b0;
    #1;
    checkOutput("ready_released", {31'd0, cfg_ready}, 32'd1);
    step(1);
    checkOutput("ready_in_reload", {31'd0, cfg_ready}, 32'd0);
    checkOutput("os_in_reload", {31'd0, os_tick}, 32'd0);
    cfg_valid = 1'b0;
    waitStrobe(0, 100, gap);
    checkOutput("first_os_after_reload", gap, 32'd4);
    waitStrobe(0, 100, gap);
    checkOutput("new_period", gap, 32'd4);

    // RX anchoring: sample 32 cycles after rx_start, then every 64.
    rx_busy  = 1'b1;
    rx_start = 1'b1;
    step(1);
    rx_start = 1'b0;
    waitStrobe(2, 200, gap);
    checkOutput("first_rx_sample", gap, 32'd31);
    waitStrobe(2, 200, gap);
    checkOutput("rx_sample_period", gap, 32'd64);

    // rx_start on the edge where a tick would be registered.
    step(3);
    checkOutput("pre_coincide_os", {31'd0, os_tick}, 32'd0);
    rx_start = 1'b1;
    step(1);
    rx_start = 1'b0;
    checkOutput("coincide_suppressed", {31'd0, os_tick}, 32'd0);
    waitStrobe(0, 100, gap);
    checkOutput("coincide_next_os", gap, 32'd3);
    waitStrobe(2, 200, gap);
    checkOutput("coincide_rx_sample", gap, 32'd28);

    // Disable halts ticks; re-enable restarts with D=3.
    rx_busy = 1'b0;
    en      = 1'b0;
    count   = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (os_tick) count++;
    end
    checkOutput("off_no_ticks", count, 32'd0);
    en = 1'b1;
    waitStrobe(0, 100, gap);
    checkOutput("reenable_os_gap", gap, 32'd4);

    // D=9 with frac=8: 32 periods.
    applyStimulus(1'b1, 16'd9, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    waitStrobe(0, 100, gap);
    checkOutput("dither_first_os", gap, 32'd10);
    total = 0;
    for (int i = 0; i < 32; i++) begin
      waitStrobe(0, 100, gap);
      total += gap;
    end
    checkOutput("dither_32_ticks", total, DITHER_SUM);

    // Reset during RELOAD drops the pending divisor.
    applyStimulus(1'b1, 16'd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    checkOutput("reload_entered", {31'd0, cfg_ready}, 32'd0);
    rst_n = 1'b0;
    step(1);
    checkOutput("rst_os_tick", {31'd0, os_tick}, 32'd0);
    checkOutput("rst_tx_tick", {31'd0, tx_tick}, 32'd0);
    checkOutput("rst_rx_sample", {31'd0, rx_sample}, 32'd0);
    checkOutput("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    waitStrobe(0, 100, gap);
    checkOutput("rst_default_div", gap, 32'd27);
    waitStrobe(0, 100, gap);
    checkOutput("rst_default_period", gap, 32'd27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_clk_ctrl.md
# uart_clk_ctrl

Baud-clock scheduler for the UART generator path. Derives one-cycle oversample, TX bit and RX mid-bit sample strobes from the single system clock with a programmable divisor. Shares one divider between the TX and RX engines. Applies divisor changes only when both engines are idle.

## Interface
Parameters:
- `DIV_W`, 16: divisor width.
- `OSR`, 16: oversample ratio, a power of two ≥ 4.
- `DEFAULT_DIV`, 26: divisor loaded at reset.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: run enable. Low halts and clears the counters.
- `cfg_div` in DIV_W: requested divisor D. Oversample period is D+1 clocks.
- `cfg_frac` in 4: fractional extension, used only with dither (see Configuration).
- `cfg_valid` in 1: config request.
- `cfg_ready` out 1: config accept. The transfer occurs when `cfg_valid && cfg_ready`.
- `tx_busy` in 1: TX engine mid-frame.
- `rx_busy` in 1: RX engine mid-frame.
- `rx_start` in 1: one-cycle pulse on a detected start-bit falling edge.
- `os_tick` out 1: oversample strobe.
- `tx_tick` out 1: TX bit strobe, every OSR `os_tick`s.
- `rx_sample` out 1: RX mid-bit sample strobe.

## Operation
- States:
  - OFF: counters held at 0, no ticks.
  - RUN: counting.
  - RELOAD: one cycle; the new divisor is applied.
- State transitions:
  - OFF→RUN when `en`=1.
  - Any state→OFF when `en`=0.
  - RUN→RELOAD on config accept.
  - RELOAD→RUN unconditionally.
  - Config accept in OFF stays in OFF.
- `cfg_ready` = !`tx_busy` && !`rx_busy` && state≠RELOAD. It is combinational.
- Accept latches `cfg_div`/`cfg_frac` into `div_q`/`frac_q`. RELOAD clears all counters.
- Divider counter:
  - Loads `div_q` and counts down.
  - At 0 it asserts `os_tick` and reloads.
  - D=0 gives `os_tick` on every RUN cycle.
- TX phase counter (log2 OSR bits) increments on each `os_tick` and wraps. `tx_tick` = `os_tick` && phase==OSR-1.
- RX phase counter:
  - Independent of the TX phase counter.
  - Cleared to 0 by `rx_start`; the divider is also reloaded in that cycle, so bit timing is anchored to the start edge.
  - `rx_sample` = `os_tick` && rx_phase==OSR/2-1 && `rx_busy`.
- `rx_start` and `os_tick` in the same cycle: `rx_start` wins. No tick is emitted and the phase is cleared.
- Config accept and `rx_start` in the same cycle cannot occur, because `rx_busy` gates `cfg_ready`. If `rx_busy` rises in the accept cycle, the accept still completes.
- Arithmetic is unsigned. Counters wrap modulo their width, and no saturation is needed.

## Timing
- Reset values: state=OFF, `div_q`=DEFAULT_DIV, `frac_q`=0, all counters 0. `os_tick`, `tx_tick` and `rx_sample` are 0. `cfg_ready` follows its equation (1 if both busy inputs are low).
- All strobes are registered and last exactly one cycle.
- First `os_tick` occurs D+1 cycles after the cycle `en` is sampled high.
- After an accept in cycle t: RELOAD in t+1, counting from t+2, first `os_tick` at t+2+D.
- `tx_tick` period is OSR·(D+1) cycles.
- First `rx_sample` occurs (OSR/2)·(D+1) cycles after `rx_start`.
- Reset asserted mid-operation: all outputs return to reset values on the next edge and any pending RELOAD is dropped.

## Configuration
- `UART_CLK_CTRL_DITHER_EN` defined:
  - A 4-bit accumulator adds `frac_q` on each `os_tick`.
  - On carry, the next oversample period is D+2 instead of D+1.
  - Average period is D+1+frac/16.
  - The accumulator is cleared by reset, RELOAD and `rx_start`.
- Undefined: `cfg_frac` is ignored, no accumulator exists, and the period is always D+1.

## Structure
- Package `uart_clk_pkg`:
  - state enum `uart_clk_state_e` (OFF, RUN, RELOAD);
  - `OSR_DEFAULT`;
  - `DIV_W_DEFAULT`;
  - `PHASE_W` function (clog2 of OSR).
- Sub-module `uart_clk_div`: loadable down-counter with reload and terminal strobe, plus the optional dither accumulator.
- Phase counters and the FSM live in the top level.

## Test plan
- Reset then `en`=1 with D=26, OSR=16 → `os_tick` every 27 cycles, first at cycle 27; `tx_tick` every 432 cycles.
- Config D=3 while `tx_busy`=1 → `cfg_ready`=0 and the old period is retained. Drop `tx_busy` → accept, RELOAD for one cycle, `os_tick` period becomes 4.
- `rx_busy`=1 with an `rx_start` pulse, D=3 → `rx_sample` 32 cycles after `rx_start`, then every 64 cycles.
- `rx_start` coincident with an `os_tick` → no tick that cycle, RX phase 0, next `os_tick` 4 cycles later (D=3).
- With DITHER_EN, D=9, frac=8 → periods alternate 10/11; 32 ticks take exactly 336 cycles. Without DITHER_EN → 320 cycles.
- `rst_n`=0 asserted mid-RELOAD → next cycle: state OFF, `div_q`=26, all strobes 0.
